// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: op encodings, FSM states and op-decoding helpers for the iterative MDU
package mdu_iter_pkg;

    localparam int MduOpWidth = 4;

    localparam logic [MduOpWidth-1:0] MduMul    = 4'd0;
    localparam logic [MduOpWidth-1:0] MduMulh   = 4'd1;
    localparam logic [MduOpWidth-1:0] MduMulhsu = 4'd2;
    localparam logic [MduOpWidth-1:0] MduMulhu  = 4'd3;
    localparam logic [MduOpWidth-1:0] MduDiv    = 4'd4;
    localparam logic [MduOpWidth-1:0] MduDivu   = 4'd5;
    localparam logic [MduOpWidth-1:0] MduRem    = 4'd6;
    localparam logic [MduOpWidth-1:0] MduRemu   = 4'd7;
    localparam logic [MduOpWidth-1:0] MduMulw   = 4'd8;
    localparam logic [MduOpWidth-1:0] MduDivw   = 4'd9;
    localparam logic [MduOpWidth-1:0] MduDivuw  = 4'd10;
    localparam logic [MduOpWidth-1:0] MduRemw   = 4'd11;
    localparam logic [MduOpWidth-1:0] MduRemuw  = 4'd12;

    typedef enum logic [1:0] {MduIdle, MduCalc, MduDone} MduState;

    function automatic logic [MduOpWidth-1:0] normOp(input logic [MduOpWidth-1:0] op);
        return (op > MduRemuw) ? MduMul : op;
    endfunction

    function automatic logic isWordOp(input logic [MduOpWidth-1:0] op);
        return op inside {MduMulw, MduDivw, MduDivuw, MduRemw, MduRemuw};
    endfunction

    function automatic logic isDivOp(input logic [MduOpWidth-1:0] op);
        return !(op inside {MduMul, MduMulh, MduMulhsu, MduMulhu, MduMulw});
    endfunction

    function automatic logic isRemOp(input logic [MduOpWidth-1:0] op);
        return op inside {MduRem, MduRemu, MduRemw, MduRemuw};
    endfunction

    function automatic logic signedA(input logic [MduOpWidth-1:0] op);
        return op inside {MduMulh, MduMulhsu, MduDiv, MduRem, MduDivw, MduRemw};
    endfunction

    function automatic logic signedB(input logic [MduOpWidth-1:0] op);
        return op inside {MduMulh, MduDiv, MduRem, MduDivw, MduRemw};
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: shared 2*XLEN accumulator doing one shift-add multiply or
// restoring-divide step per cycle on unsigned magnitudes
module mdu_iter_core #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              isDiv,
    input  logic [XLEN-1:0]   opB,
    input  logic [XLEN-1:0]   initLo,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0] b;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;

    // partial remainder stays below the divisor, so a 65-bit difference flags the borrow in its MSB
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
        diff = acc[2*XLEN-1:XLEN-1] - {1'b0, b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            b   <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, initLo};
            b   <= opB;
        end else if (step) begin
            acc <= !isDiv ? {sum, acc[XLEN-1:1]} :
                   diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit; operand conditioning, FSM and
// valid/ready handshakes around the shared mdu_iter_core datapath
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OPW  = MduOpWidth
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  mdu_op,
    input  logic [XLEN-1:0] operator_1,
    input  logic [XLEN-1:0] operator_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_result
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    MduState state, stateNext;
    logic [CW-1:0] cnt;
    logic [OPW-1:0] op;
    logic word, sA, sB, divOp, remOp, negA, negB, divZero, ovf, special, negIn, accept;
    logic [XLEN-1:0] a, b, magA, magB, dividend, specialRes, coreB, coreLo;
    logic wordR, divR, remR, negR, specR, mulLowR;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0] divVal, divS, mulRes, divRes;

    assign in_ready = state == MduIdle;
    assign out_valid = state == MduDone;
    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        op = normOp(mdu_op);
        word = isWordOp(op);
        sA = signedA(op);
        sB = signedB(op);
        divOp = isDivOp(op);
        remOp = isRemOp(op);
        a = word ? {{HALF{sA & operator_1[HALF-1]}}, operator_1[HALF-1:0]} : operator_1;
        b = word ? {{HALF{sB & operator_2[HALF-1]}}, operator_2[HALF-1:0]} : operator_2;
        negA = sA & a[XLEN-1];
        negB = sB & b[XLEN-1];
        magA = negA ? -a : a;
        magB = negB ? -b : b;
        dividend = word ? {{HALF{operator_1[HALF-1]}}, operator_1[HALF-1:0]} : operator_1;
        divZero = b == '0;
        // a is already sign-extended for word ops, so the most-negative pattern covers both widths
        ovf = sA && b == '1 && a == (word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}});
        special = divOp && (divZero || ovf);
        specialRes = remOp ? (divZero ? dividend : '0) : (divZero ? '1 : dividend);
        coreB = divOp ? magB : magA;
        coreLo = !divOp ? magB : word ? magA << HALF : magA;
        negIn = remOp ? negA : negA ^ negB;
    end

    always_comb begin
        prod = negR ? -acc : acc;
        divVal = remR ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        divS = negR ? -divVal : divVal;
        mulRes = wordR ? {{HALF{acc[XLEN-1]}}, acc[XLEN-1:HALF]} : mulLowR ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        divRes = wordR ? {{HALF{divS[HALF-1]}}, divS[HALF-1:0]} : divS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MduIdle;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (flush) stateNext = MduIdle;
        else if (state == MduIdle && in_valid) stateNext = MduCalc;
        else if (state == MduCalc && cnt == '0) stateNext = MduDone;
        else if (state == MduDone && out_ready) stateNext = MduIdle;
    end

    // a bypassed op spends a single zero-count cycle before DONE and keeps its preloaded result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            {wordR, divR, remR, negR, specR, mulLowR} <= '0;
            mdu_result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= special ? CW'(0) : word ? CW'(HALF) : CW'(XLEN);
            {wordR, divR, remR, negR, specR, mulLowR} <= {word, divOp, remOp, negIn, special, op == MduMul};
            if (special) mdu_result <= specialRes;
        end else if (state == MduCalc) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else if (!specR) mdu_result <= divR ? divRes : mulRes;
        end
    end

    mdu_iter_core #(.XLEN(XLEN)) core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state == MduCalc && cnt != '0 && !flush),
        .isDiv  (divR),
        .opB    (coreB),
        .initLo (coreLo),
        .acc    (acc)
    );

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed bench for mdu_iter; expected results go into a queue at
// issue time and are popped when out_valid appears
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic clk = 0;
    logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] mdu_op;
    logic [63:0] operator_1, operator_2, mdu_result;
    logic [63:0] sb[$];
    logic [63:0] hold, junk;
    logic ok;
    int errors = 0;
    int checks = 0;

    mdu_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdu_op     (mdu_op),
        .operator_1 (operator_1),
        .operator_2 (operator_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mdu_result (mdu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic signed [63:0] sa, sb64, q64;
        logic signed [31:0] wa, wb, q32;
        logic [31:0] ua, ub, r32;
        logic [63:0] r;
        sa = a; sb64 = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        r = '0; r32 = '0; p = '0;
        case (op)
            MduMulh:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            MduMulhsu: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
            MduMulhu:  begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            MduDiv: begin
                if (b == 0) r = '1;
                else if (a == 64'h8000000000000000 && b == '1) r = a;
                else begin q64 = sa / sb64; r = q64; end
            end
            MduDivu: r = (b == 0) ? '1 : a / b;
            MduRem: begin
                if (b == 0) r = a;
                else if (a == 64'h8000000000000000 && b == '1) r = '0;
                else begin q64 = sa % sb64; r = q64; end
            end
            MduRemu: r = (b == 0) ? a : a % b;
            MduMulw: r32 = ua * ub;
            MduDivw: begin
                if (ub == 0) r32 = '1;
                else if (ua == 32'h80000000 && ub == '1) r32 = ua;
                else begin q32 = wa / wb; r32 = q32; end
            end
            MduDivuw: r32 = (ub == 0) ? '1 : ua / ub;
            MduRemw: begin
                if (ub == 0) r32 = ua;
                else if (ua == 32'h80000000 && ub == '1) r32 = '0;
                else begin q32 = wa % wb; r32 = q32; end
            end
            MduRemuw: r32 = (ub == 0) ? ua : ua % ub;
            default: r = a * b;
        endcase
        if (op inside {[MduMulw:MduRemuw]}) r = {{32{r32[31]}}, r32};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        @(negedge clk);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        mdu_op = op; operator_1 = a; operator_2 = b; in_valid = 1;
        sb.push_back(exp);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic waitOut(input string tag, input int expLat);
        int lat = 0;
        logic busy = 1;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            busy &= !in_ready;
            @(posedge clk);
            #1;
            if (out_valid) lat = n;
        end
        busy &= !in_ready;
        chk({tag, "_latency"}, 64'(lat), 64'(expLat));
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_result"}, mdu_result, sb.pop_front());
    endtask

    task automatic take(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_ready_after"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        mdu_op = '0; operator_1 = '0; operator_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {in_ready, out_valid, mdu_result[61:0]}, {2'b10, 62'd0});
        @(negedge clk) rst_n = 1;

        issue("mul", MduMul, 64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB);
        waitOut("mul", 65); take("mul");
        issue("mulhu", MduMulhu, '1, '1, 64'hFFFFFFFFFFFFFFFE);
        waitOut("mulhu", 65); take("mulhu");
        issue("mulhsu", MduMulhsu, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF);
        waitOut("mulhsu", 65); take("mulhsu");
        issue("div", MduDiv, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD);
        waitOut("div", 65); take("div");
        issue("rem", MduRem, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF);
        waitOut("rem", 65); take("rem");
        issue("divw_ovf", MduDivw, 64'h80000000, '1, 64'hFFFFFFFF80000000);
        waitOut("divw_ovf", 1); take("divw_ovf");
        issue("remw_ovf", MduRemw, 64'h80000000, '1, 64'd0);
        waitOut("remw_ovf", 1); take("remw_ovf");
        issue("divu_zero", MduDivu, 64'd5, 64'd0, '1);
        waitOut("divu_zero", 1); take("divu_zero");
        issue("remu_zero", MduRemu, 64'd5, 64'd0, 64'd5);
        waitOut("remu_zero", 1); take("remu_zero");

        issue("mulh", MduMulh, 64'h8000000000000000, 64'h8000000000000000, model(MduMulh, 64'h8000000000000000, 64'h8000000000000000));
        waitOut("mulh", 65); take("mulh");
        issue("mulw", MduMulw, 64'hDEAD00007FFFFFFF, 64'hBEEF000000000002, model(MduMulw, 64'hDEAD00007FFFFFFF, 64'hBEEF000000000002));
        waitOut("mulw", 33); take("mulw");
        issue("divw", MduDivw, 64'h00000000FFFFFF9C, 64'h1234000000000007, model(MduDivw, 64'h00000000FFFFFF9C, 64'h1234000000000007));
        waitOut("divw", 33); take("divw");
        issue("remuw", MduRemuw, 64'hABCD0000FFFFFFFF, 64'h000000000000000A, model(MduRemuw, 64'hABCD0000FFFFFFFF, 64'h000000000000000A));
        waitOut("remuw", 33); take("remuw");
        issue("rem_ovf", MduRem, 64'h8000000000000000, '1, model(MduRem, 64'h8000000000000000, '1));
        waitOut("rem_ovf", 1); take("rem_ovf");
        issue("div_zero", MduDiv, 64'd9, 64'd0, model(MduDiv, 64'd9, 64'd0));
        waitOut("div_zero", 1); take("div_zero");
        issue("remw_zero", MduRemw, 64'h1FFFFFFF9, 64'hFFFFFFFF00000000, model(MduRemw, 64'h1FFFFFFF9, 64'hFFFFFFFF00000000));
        waitOut("remw_zero", 1); take("remw_zero");
        issue("unused_op", 4'd13, 64'h123456789, 64'hFEDCBA987, model(4'd13, 64'h123456789, 64'hFEDCBA987));
        waitOut("unused_op", 65); take("unused_op");

        out_ready = 0;
        issue("bp", MduDivu, 64'd1000, 64'd7, model(MduDivu, 64'd1000, 64'd7));
        waitOut("bp", 65);
        hold = mdu_result; ok = 1;
        repeat (10) begin
            @(posedge clk);
            #1 ok &= mdu_result === hold && out_valid && !in_ready;
        end
        chk("bp_hold", {63'd0, ok}, 64'd1);
        out_ready = 1;
        take("bp");

        out_ready = 0;
        issue("flush_done", MduDivu, 64'd5, 64'd0, '1);
        waitOut("flush_done", 1);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_done_drop", {62'd0, in_ready, out_valid}, 64'b10);
        out_ready = 1;

        issue("flush_calc", MduMul, 64'd3, 64'd4, 64'd12);
        junk = sb.pop_front();
        repeat (19) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_calc_idle", {62'd0, in_ready, out_valid}, 64'b10);
        ok = 1;
        repeat (80) begin
            @(posedge clk);
            #1 ok &= !out_valid;
        end
        chk("flush_calc_silent", {63'd0, ok}, 64'd1);

        @(negedge clk);
        mdu_op = MduDivu; operator_1 = 64'd5; operator_2 = 64'd0; in_valid = 1; flush = 1;
        @(posedge clk);
        #1 in_valid = 0; flush = 0;
        ok = in_ready;
        repeat (3) begin
            @(posedge clk);
            #1 ok &= in_ready && !out_valid;
        end
        chk("flush_blocks_accept", {63'd0, ok}, 64'd1);

        issue("rst_mid", MduDiv, 64'd1000, 64'd3, 64'd333);
        junk = sb.pop_front();
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1 chk("rst_async", {in_ready, out_valid, mdu_result[61:0]}, {2'b10, 62'd0});
        chk("rst_async_hi", {62'd0, mdu_result[63:62]}, 64'd0);
        @(negedge clk) rst_n = 1;
        issue("divuw", MduDivuw, 64'd100, 64'd7, 64'd14);
        waitOut("divuw", 33); take("divuw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
